// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the sequential ALU.
package alu_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int ADDRW_DEF = 3;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle result for FORWARD/ADD/AND/OR; reserved and iterative opcodes yield zero.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_FWD:  y_o = b_i;
            OP_ADD:  y_o = a_i + b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic/add in 1 cycle, MUL in 8, SHL by k in max(k,1); result written back via WRITE_EN.
// START is only sampled in IDLE; requests arriving while BUSY are dropped, not queued.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ADDRW = ADDRW_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [ADDRW-1:0] DESTADDR,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output logic             WRITE_EN,
    output logic [ADDRW-1:0] WRITEADDR
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [2:0]       cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, busy_q, done_q;
    logic [ADDRW-1:0] waddr_q;

    logic [WIDTH-1:0] comb_y, mul_sum, fin_dat;
    logic             fin_vld;
    logic [2:0]       shamt;

    assign shamt   = DATA2[2:0];
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op_i (SELECT),
        .a_i  (DATA1),
        .b_i  (DATA2),
        .y_o  (comb_y)
    );

    always_comb begin
        state_d = state_q;
        fin_vld = 1'b0;
        fin_dat = '0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    if (SELECT == OP_MUL) begin
                        state_d = MUL;
                    end else if (SELECT == OP_SHL && shamt > 3'd1) begin
                        state_d = SHIFT;
                    end else begin
                        fin_vld = 1'b1;
                        if (SELECT == OP_SHL)
                            fin_dat = (shamt == 3'd0) ? DATA1 : (DATA1 << 1);
                        else
                            fin_dat = comb_y;
                    end
                end
            end
            MUL: begin
                if (cnt_q == 3'd7) begin
                    fin_vld = 1'b1;
                    fin_dat = mul_sum;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == 3'd1) begin
                    fin_vld = 1'b1;
                    fin_dat = acc_q << 1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The accepting edge already performs the first MUL step / first shift, giving latencies 8 and k.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= 3'd0;
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            waddr_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= fin_vld;
            if (fin_vld) begin
                result_q <= fin_dat;
                zero_q   <= (fin_dat == '0);
            end
            case (state_q)
                IDLE: begin
                    if (START) begin
                        waddr_q  <= DESTADDR;
                        acc_q    <= (SELECT == OP_MUL) ? (DATA2[0] ? DATA1 : '0) : (DATA1 << 1);
                        mcand_q  <= DATA1 << 1;
                        mplier_q <= DATA2 >> 1;
                        cnt_q    <= (SELECT == OP_MUL) ? 3'd1 : (shamt - 3'd1);
                    end
                end
                MUL: begin
                    acc_q    <= mul_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 3'd1;
                end
                SHIFT: begin
                    acc_q <= acc_q << 1;
                    cnt_q <= cnt_q - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign RESULT    = result_q;
    assign ZERO      = zero_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign WRITE_EN  = done_q;
    assign WRITEADDR = waddr_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [2:0] SELECT;
    logic [7:0] DATA1, DATA2;
    logic [2:0] DESTADDR;
    logic [7:0] RESULT;
    logic       ZERO, BUSY, DONE, WRITE_EN;
    logic [2:0] WRITEADDR;

    int n_chk  = 0;
    int n_fail = 0;

    alu_seq dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SELECT    (SELECT),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .DESTADDR  (DESTADDR),
        .RESULT    (RESULT),
        .ZERO      (ZERO),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .WRITE_EN  (WRITE_EN),
        .WRITEADDR (WRITEADDR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_result(input int op, input int a, input int b);
        case (op)
            0:       return 8'(b);
            1:       return 8'((a + b) % 256);
            2:       return 8'(a & b);
            3:       return 8'(a | b);
            4:       return 8'((a * b) % 256);
            5:       return 8'((a * (1 << (b % 8))) % 256);
            default: return 8'h00;
        endcase
    endfunction

    function automatic int ref_latency(input int op, input int b);
        if (op == 4) return 8;
        if (op == 5 && (b % 8) > 0) return b % 8;
        return 1;
    endfunction

    // chain: leave in the DONE cycle so the next request lands on the edge after DONE.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] d, input bit noise, input bit chain);
        logic [7:0] exp_res;
        int         exp_lat, lat, busy_n;
        exp_res = ref_result(int'(op), int'(a), int'(b));
        exp_lat = ref_latency(int'(op), int'(b));
        @(negedge CLK);
        START = 1'b1; SELECT = op; DATA1 = a; DATA2 = b; DESTADDR = d;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!DONE && lat < 20) begin
            if (BUSY) busy_n++;
            if (noise) begin
                START = 1'b1; SELECT = 3'($urandom_range(0, 7));
                DATA1 = 8'($urandom); DATA2 = 8'($urandom); DESTADDR = 3'($urandom);
            end
            @(posedge CLK); #1;
            START = 1'b0;
            lat++;
        end
        check("done", 32'(DONE), 32'd1);
        if (DONE) begin
            check("latency", 32'(lat), 32'(exp_lat));
            check("result", 32'(RESULT), 32'(exp_res));
            check("zero", 32'(ZERO), 32'(exp_res == 8'h00));
            check("write_en", 32'(WRITE_EN), 32'd1);
            check("writeaddr", 32'(WRITEADDR), 32'(d));
            check("busy_in_done", 32'(BUSY), 32'd0);
            check("busy_cycles", 32'(busy_n), 32'(exp_lat - 1));
        end
        if (!chain) begin
            @(posedge CLK); #1;
            check("done_pulse", 32'(DONE), 32'd0);
            check("wen_pulse", 32'(WRITE_EN), 32'd0);
            check("result_held", 32'(RESULT), 32'(exp_res));
            check("waddr_held", 32'(WRITEADDR), 32'(d));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, 32'(RESULT), 32'h00);
        check({tag, "_zero"}, 32'(ZERO), 32'd1);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_done"}, 32'(DONE), 32'd0);
        check({tag, "_wen"}, 32'(WRITE_EN), 32'd0);
        check({tag, "_waddr"}, 32'(WRITEADDR), 32'd0);
    endtask

    initial begin
        bit seen;
        RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0; DESTADDR = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        RESET = 1'b0;

        run_op(3'd1, 8'h05, 8'h03, 3'd2, 1'b0, 1'b0);
        run_op(3'd4, 8'h0F, 8'h11, 3'd5, 1'b0, 1'b0);
        run_op(3'd4, 8'h10, 8'h10, 3'd1, 1'b0, 1'b0);
        run_op(3'd4, 8'hFF, 8'hFF, 3'd7, 1'b0, 1'b0);
        run_op(3'd5, 8'h81, 8'h0B, 3'd3, 1'b0, 1'b0);
        run_op(3'd5, 8'h81, 8'h08, 3'd4, 1'b0, 1'b0);
        run_op(3'd5, 8'hC3, 8'h01, 3'd6, 1'b0, 1'b0);
        run_op(3'd6, 8'h12, 8'h34, 3'd1, 1'b0, 1'b0);
        run_op(3'd4, 8'h0F, 8'h11, 3'd6, 1'b1, 1'b1);
        run_op(3'd2, 8'hF0, 8'h3C, 3'd3, 1'b0, 1'b1);
        run_op(3'd5, 8'h01, 8'h07, 3'd5, 1'b1, 1'b0);

        // Abort a multiply mid-flight; START held during reset must also be ignored.
        @(negedge CLK);
        START = 1'b1; SELECT = 3'd4; DATA1 = 8'h37; DATA2 = 8'h29; DESTADDR = 3'd6;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_outputs("abort");
        START = 1'b1; SELECT = 3'd1; DATA1 = 8'h11; DATA2 = 8'h22; DESTADDR = 3'd4;
        seen = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (DONE || WRITE_EN || BUSY) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_result", 32'(RESULT), 32'h00);
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        run_op(3'd1, 8'hFF, 8'h01, 3'd3, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 3'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
